// File: rtl/zymason_pkg.sv
// Shared types and constants for the Zymason_Tiny1 entry sequencer.
//   seq_state_t : sequencer FSM states
//   HOLD_DEF / GAP_DEF / SETTLE_DEF : default phase lengths in clock cycles
//   CNT_W       : width of the phase down-counter
//   phase_load  : counter preload value for a phase of a given length
package zymason_pkg;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned HOLD_DEF   = 4;
  localparam int unsigned GAP_DEF    = 2;
  localparam int unsigned SETTLE_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_GAP0,
    S_WR1,
    S_GAP1,
    S_RD,
    S_DONE
  } seq_state_t;

  // A phase of len cycles starts at len-1 and advances when the count reaches 0.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/pin_sequencer_timer.sv
// seq_timer: loadable phase down-counter with a zero flag.
//   clock_i    : system clock
//   reset_n_i  : synchronous active-low reset (count -> 0)
//   clr_i      : force count to 0 (highest priority after reset)
//   load_i     : load load_val_i
//   load_val_i : preload value
//   zero_o     : count is 0; the counter holds at 0 instead of wrapping
module seq_timer
  import zymason_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pin_sequencer.sv
// pin_sequencer: scripted entry controller for the Zymason_Tiny1 lock.
// On start it writes digit 0, then digit 1, then reads back the lock state
// and reports it against an expected value.
//   clock, reset_n      : clock, synchronous active-low reset
//   start, abort        : begin a sequence (IDLE only) / return to IDLE
//   code_in, expect_st  : digits {d1,d0} and expected state, captured on start
//   st_in               : lock st_out feedback
//   RW, sel, pin_in     : lock write strobe, digit select, digit value
//   busy, done          : not IDLE / one-cycle result-valid pulse
//   result_st, match    : sampled st_in and its comparison, held until next start
module pin_sequencer
  import zymason_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = HOLD_DEF,
  parameter int unsigned GAP_CYC    = GAP_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] code_in,
  input  logic [1:0] expect_st,
  input  logic [1:0] st_in,
  output logic       RW,
  output logic       sel,
  output logic [3:0] pin_in,
  output logic       busy,
  output logic       done,
  output logic [1:0] result_st,
  output logic       match
);

  seq_state_t       state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic [1:0]       exp_q, exp_d;
  logic             tmr_clr, tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             accept, sample;

  seq_timer u_timer (
    .clock_i    (clock),
    .reset_n_i  (reset_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    exp_d    = exp_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    sample   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          accept   = 1'b1;
          code_d   = code_in;
          exp_d    = expect_st;
          state_d  = S_WR0;
          tmr_load = 1'b1;
          tmr_val  = phase_load(HOLD_CYC);
        end
        S_WR0: if (tmr_zero) begin
          state_d  = S_GAP0;
          tmr_load = 1'b1;
          tmr_val  = phase_load(GAP_CYC);
        end
        S_GAP0: if (tmr_zero) begin
          state_d  = S_WR1;
          tmr_load = 1'b1;
          tmr_val  = phase_load(HOLD_CYC);
        end
        S_WR1: if (tmr_zero) begin
          state_d  = S_GAP1;
          tmr_load = 1'b1;
          tmr_val  = phase_load(GAP_CYC);
        end
        S_GAP1: if (tmr_zero) begin
          state_d  = S_RD;
          tmr_load = 1'b1;
          tmr_val  = phase_load(SETTLE_CYC);
        end
        S_RD: if (tmr_zero) begin
          sample  = 1'b1;
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q
  // while still being registered; pin_in uses code_d so digit 0 is valid
  // in the first WR0 cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      exp_q     <= '0;
      RW        <= 1'b0;
      sel       <= 1'b0;
      pin_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_st <= '0;
      match     <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      exp_q   <= exp_d;
      RW      <= (state_d == S_WR0) || (state_d == S_WR1);
      sel     <= (state_d == S_WR1);
      if (state_d == S_WR0) begin
        pin_in <= code_d[3:0];
      end else if (state_d == S_WR1) begin
        pin_in <= code_d[7:4];
      end else begin
        pin_in <= '0;
      end
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
      if (accept) begin
        result_st <= '0;
        match     <= 1'b0;
      end else if (sample) begin
        result_st <= st_in;
        match     <= (st_in == exp_q);
      end
    end
  end

endmodule

// File: doc/pin_sequencer.md
# pin_sequencer

Scripted entry controller for the Zymason_Tiny1 lock datapath. On a `start` command it drives the lock's `RW`/`sel`/`pin_in` inputs through a fixed write-digit-0, write-digit-1, read sequence with programmable hold, gap and settle times. It then samples the lock's `st_out` state and reports whether it matches an expected value. It sits between the board-level interface (switches or a test harness) and Zymason_Tiny1, replacing hand-toggled switches on the FPGA demo and in regression.

## Interface
- `HOLD_CYC`, default 4: cycles each digit is held with `RW`=1 (legal range 1..15).
- `GAP_CYC`, default 2: idle cycles after each write (legal range 1..15).
- `SETTLE_CYC`, default 3: read-phase cycles before `st_in` is sampled (legal range 1..15).
- `clock`  in  1  single system clock (the ~6.1 kHz divided clock on the board).
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a sequence; honoured only in IDLE.
- `abort`  in  1  return to IDLE next cycle from any state.
- `code_in`  in  8  `[3:0]` is digit 0, `[7:4]` is digit 1; captured on an accepted start.
- `expect_st`  in  2  expected lock state; captured on an accepted start.
- `st_in`  in  2  lock `st_out` feedback.
- `RW`  out  1  to lock; 1 means write.
- `sel`  out  1  to lock; digit select.
- `pin_in`  out  4  to lock; digit value.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result_st`  out  2  sampled `st_in`; held until the next accepted start.
- `match`  out  1  `result_st` == captured `expect_st`; held with `result_st`.

## Operation
- States: IDLE, WR0, GAP0, WR1, GAP1, RD, DONE.
- IDLE:
  - Drives `RW`=0, `sel`=0, `pin_in`=0.
  - `start`=1 latches `code_in` and `expect_st`, clears `result_st` and `match`, then moves to WR0.
- WR0: `RW`=1, `sel`=0, `pin_in`=code[3:0] for `HOLD_CYC` cycles, then GAP0.
- GAP0: `RW`=0, `sel`=0, `pin_in`=0 for `GAP_CYC` cycles, then WR1.
- WR1: `RW`=1, `sel`=1, `pin_in`=code[7:4] for `HOLD_CYC` cycles, then GAP1.
- GAP1: same outputs as GAP0 for `GAP_CYC` cycles, then RD.
- RD:
  - `RW`=0, `sel`=0, `pin_in`=0 for `SETTLE_CYC` cycles.
  - On the last RD cycle, `st_in` is registered into `result_st` and `match` is computed.
  - Next state is DONE.
- DONE: `done`=1 for exactly one cycle, outputs as in IDLE, then IDLE.
- Phase timing uses one down-counter, 4 bits wide. It is loaded with (phase length − 1) on entry to each timed state and the state advances when the count is 0. It is never allowed to wrap.
- `abort` has priority over every transition:
  - Next state is IDLE.
  - The counter clears.
  - `result_st` and `match` keep their previous values.
  - `done` is not pulsed.
- `start` outside IDLE is ignored, including `start` in the DONE cycle.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the sequence does not start.
- `code_in` and `expect_st` changes after capture have no effect on a running sequence.

## Timing
- Reset: while `reset_n`=0 at a clock edge, the block enters IDLE and all outputs go to 0 (`busy`, `done`, `RW`, `sel`, `pin_in`, `result_st`, `match`).
- Reset mid-sequence behaves the same as reset at any other time: IDLE next cycle, no `done` pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle numbering: `start` sampled at edge 0. `busy` and WR0 outputs appear at cycle 1.
- Defaults: WR0 cycles 1–4, GAP0 5–6, WR1 7–10, GAP1 11–12, RD 13–15.
  - `st_in` is sampled at the end of cycle 15.
  - `done`, `result_st` and `match` are valid in cycle 16.
  - IDLE resumes in cycle 17.
- General latency from start to `done`: 1 + 2·HOLD + 2·GAP + SETTLE cycles.
- Back-to-back operation: a `start` in cycle 17 (the first IDLE cycle) is accepted.

## Structure
- `zymason_pkg` holds:
  - `seq_state_t`, the enum of the 7 states.
  - Default constants `HOLD_DEF`, `GAP_DEF` and `SETTLE_DEF`.
  - `CNT_W` = 4.
- One sub-module, `seq_timer`: a loadable down-counter with a `zero` flag. The FSM in `pin_sequencer` loads it on each state entry.
- Top-level FPGA wiring can select either switches or `pin_sequencer` as the lock's input source. That mux lives outside this block.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles mid-WR1 → IDLE next cycle; all outputs 0; no `done` pulse.
- Nominal: `code_in`=8'h5A, `expect_st`=2'b10, `st_in` tied to 2'b10 → `pin_in`=A in cycles 1–4 and 5 in cycles 7–10; `sel`=1 only in cycles 7–10; `done` in cycle 16 with `result_st`=2'b10, `match`=1.
- Mismatch: same code, `st_in`=2'b01 → `done` in cycle 16, `match`=0, `result_st`=2'b01; both values held through IDLE.
- Abort: `abort` in cycle 8 → IDLE in cycle 9; `RW`=0; no `done`; previous `result_st` retained; a new `start` is accepted.
- Ignored starts: pulse `start` in cycles 5 and 16, and change `code_in` during the run → exactly one `done`; the digit sequence matches the originally captured code.
- Parameter sweep: HOLD=1, GAP=1, SETTLE=1 → `done` in cycle 6; HOLD=15, GAP=15, SETTLE=15 → `done` in cycle 76, with no counter wrap.
